// File: rtl/lz77_decoder_param.sv
// Parametrised LZ77 decoder: expands (pos, len, literal) codewords into a byte
// stream through a shift-register search buffer, one symbol per cycle with backpressure.
module lz77_decoder_param #(
    parameter int                DATA_W       = 8,
    parameter int                SEARCH_DEPTH = 9,
    parameter int                MAX_LEN      = 7,
    parameter logic [DATA_W-1:0] END_CHAR     = DATA_W'('h24),
    parameter int                LEN_W        = $clog2(MAX_LEN + 1),
    parameter int                POS_W        = $clog2(SEARCH_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [POS_W-1:0]  code_pos,
    input  logic [LEN_W-1:0]  code_len,
    input  logic [DATA_W-1:0] chardata,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [DATA_W-1:0] char_nxt,
    output logic              encode,
    output logic              finish,
    output logic              err_pos
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(SEARCH_DEPTH - 1);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);

    state_t            state;
    logic [DATA_W-1:0] search_buf [SEARCH_DEPTH];
    logic [POS_W-1:0]  pos_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] lit_q;
    logic              accept;
    logic              xfer;

    assign code_ready = (state == IDLE);
    assign char_valid = (state == COPY) || (state == LIT);
    assign finish     = (state == DONE);
    assign encode     = 1'b0;
    assign accept     = code_valid && code_ready;
    assign xfer       = char_valid && char_ready;

    // The copy distance is fixed while the buffer shifts under it, so reading
    // buf[pos] after every transfer replays overlapping runs correctly.
    always_comb begin
        // NOTE: default first so every path assigns char_nxt and no latch is inferred.
        char_nxt = '0;
        case (state)
            COPY:    char_nxt = search_buf[pos_q];
            LIT:     char_nxt = lit_q;
            default: char_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pos_q   <= '0;
            len_q   <= '0;
            lit_q   <= '0;
            err_pos <= 1'b0;
            // NOTE: the search buffer is reset because a copy issued right after
            // reset must read zeros, not stale history from an aborted stream.
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                search_buf[i] <= '0;
            end
        end else begin
            err_pos <= 1'b0;

            // NOTE: non-blocking assignments let every entry read its neighbour's
            // pre-edge value, giving a true one-step shift.
            if (xfer) begin
                search_buf[0] <= char_nxt;
                for (int i = 1; i < SEARCH_DEPTH; i++) begin
                    search_buf[i] <= search_buf[i-1];
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        len_q <= code_len;
                        lit_q <= chardata;
                        // Out-of-range distances are clamped to the oldest entry.
                        if (code_pos > LAST_POS) begin
                            pos_q   <= LAST_POS;
                            err_pos <= 1'b1;
                        end else begin
                            pos_q <= code_pos;
                        end
                        if (code_len != '0) begin
                            state <= COPY;
                        end else if (chardata != END_CHAR) begin
                            state <= LIT;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                COPY: begin
                    if (xfer) begin
                        len_q <= len_q - ONE_LEN;
                        if (len_q == ONE_LEN) begin
                            state <= (lit_q == END_CHAR) ? DONE : LIT;
                        end
                    end
                end
                LIT: begin
                    if (xfer) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_decoder_param.sv
// Self-checking bench for lz77_decoder_param: directed scenarios plus randomized
// codewords scored against a history-list model of LZ77 decoding.
module tb_lz77_decoder_param;

    localparam int          DEPTH    = 9;
    localparam logic [7:0]  END_CHAR = 8'h24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [3:0] code_pos = '0;
    logic [2:0] code_len = '0;
    logic [7:0] chardata = '0;
    logic       char_valid;
    logic       char_ready = 1'b0;
    logic [7:0] char_nxt;
    logic       encode;
    logic       finish;
    logic       err_pos;

    int checks = 0;
    int errors = 0;

    logic [7:0] hist [$];
    logic [7:0] exp_q [$];

    lz77_decoder_param dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_pos   (code_pos),
        .code_len   (code_len),
        .chardata   (chardata),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_nxt   (char_nxt),
        .encode     (encode),
        .finish     (finish),
        .err_pos    (err_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decoding from first principles: the output history starts as DEPTH zeros,
    // a copy at distance p reads the symbol p+1 places back from the newest.
    task automatic model_cw(input int p, input int l, input logic [7:0] c);
        int         pp;
        logic [7:0] b;
        pp = (p > DEPTH - 1) ? DEPTH - 1 : p;
        for (int k = 0; k < l; k++) begin
            b = hist[hist.size() - 1 - pp];
            hist.push_back(b);
            exp_q.push_back(b);
        end
        if (c != END_CHAR) begin
            hist.push_back(c);
            exp_q.push_back(c);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code_ready"}, code_ready, 1);
        check({tag, "_char_valid"}, char_valid, 0);
        check({tag, "_char_nxt"}, char_nxt, 0);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_err_pos"}, err_pos, 0);
        check({tag, "_encode"}, encode, 0);
    endtask

    // Asserts reset asynchronously mid-cycle, holds it two cycles, releases on a negedge.
    task automatic do_reset();
        #3 reset = 1'b1;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        reset = 1'b0;
        char_ready = 1'b0;
        code_valid = 1'b0;
        model_reset();
    endtask

    // Called on a negedge; leaves the bench on the negedge after acceptance.
    task automatic send_cw(input int p, input int l, input logic [7:0] c);
        int g = 0;
        while (!code_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("send_ready_timeout", (g < 20), 1);
        code_valid = 1'b1;
        code_pos   = 4'(p);
        code_len   = 3'(l);
        chardata   = c;
        model_cw(p, l, c);
        @(negedge clk);
        code_valid = 1'b0;
        check("err_pos_flag", err_pos, (p > DEPTH - 1) ? 1 : 0);
    endtask

    // mode 0: always ready; 1: random stalls; 2: ready dropped for 3 cycles.
    task automatic drain(input int mode, input int n_max);
        int   n = 0;
        int   cyc = 0;
        logic rdy;
        while (n < n_max && exp_q.size() > 0 && cyc < 300) begin
            if (cyc == 1) check("err_pos_one_cycle", err_pos, 0);
            check("char_valid", char_valid, 1);
            check("char_nxt", char_nxt, exp_q[0]);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = !(cyc >= 2 && cyc < 5);
            endcase
            char_ready = rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        char_ready = 1'b0;
        check("drain_timeout", (cyc < 300), 1);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_finish"}, finish, 1);
        check({tag, "_code_ready"}, code_ready, 0);
        check({tag, "_char_valid"}, char_valid, 0);
    endtask

    initial begin
        int p;
        int l;
        logic [7:0] c;

        // Reset values
        @(negedge clk);
        do_reset();

        // Literal-only codewords
        send_cw(0, 0, 8'h31);
        drain(0, 99);
        check("idle_after_lit1", code_ready, 1);
        send_cw(0, 0, 8'h32);
        drain(0, 99);
        check("idle_after_lit2", code_ready, 1);

        // Overlapping copy: 31 32 31 32 33 on consecutive cycles
        send_cw(1, 4, 8'h33);
        check("overlap_expected_len", exp_q.size(), 5);
        drain(0, 99);
        check("idle_after_overlap", code_ready, 1);

        // Backpressure in the middle of a copy
        send_cw(3, 5, 8'h34);
        drain(2, 99);

        // Terminating codeword: copies only, then sticky finish
        send_cw(2, 3, END_CHAR);
        check("term_expected_len", exp_q.size(), 3);
        drain(0, 99);
        check_done("term");
        code_valid = 1'b1;
        code_pos   = 4'd0;
        code_len   = 3'd0;
        chardata   = 8'h37;
        repeat (3) @(negedge clk);
        code_valid = 1'b0;
        check_done("term_ignored");

        // Reset mid-copy, then an out-of-range distance
        do_reset();
        send_cw(0, 2, 8'h41);
        drain(0, 99);
        send_cw(1, 6, 8'h35);
        drain(0, 2);
        do_reset();
        @(negedge clk);
        check_reset_outputs("post_abort_idle");
        send_cw(12, 1, 8'h41);
        drain(0, 99);
        check("idle_after_badpos", code_ready, 1);

        // Randomized codewords
        for (int n = 0; n < 60; n++) begin
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            l = $urandom_range(0, 7);
            c = 8'($urandom_range(0, 255));
            if (c == END_CHAR) c = 8'h25;
            send_cw(p, l, c);
            drain(1, 99);
        end
        send_cw($urandom_range(0, 8), $urandom_range(1, 7), END_CHAR);
        drain(1, 99);
        check_done("rand_term");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
